fbuf_write_scheduler: RTL
=========================

FBUF_WRITE_SCHEDULER -- requirements
Module: fbuf_write_scheduler

Interface
REQ-001 Parameters SHALL be:
- FBUF_ADDR_WIDTH, default 19, framebuffer address width.
- FBUF_DATA_WIDTH, default 8, pixel width.
- FRAME_PIXELS, default 307200, number of valid pixel addresses (640x480).

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock.
- rst, in, 1, asynchronous active-high reset.
- fbuf_rst_busy, in, 1, BRAM reset in progress; no writes allowed.
- r0_valid, in, 1, requester 0 (register decode path) write request.
- r0_ready, out, 1, requester 0 accept.
- r0_addr, in, FBUF_ADDR_WIDTH, requester 0 pixel address.
- r0_data, in, FBUF_DATA_WIDTH, requester 0 pixel value.
- r1_valid, in, 1, requester 1 (drawing engine) write request.
- r1_ready, out, 1, requester 1 accept.
- r1_addr, in, FBUF_ADDR_WIDTH, requester 1 pixel address.
- r1_data, in, FBUF_DATA_WIDTH, requester 1 pixel value.
- clear_start, in, 1, one-cycle pulse requesting a full-frame clear.
- clear_color, in, FBUF_DATA_WIDTH, fill value, sampled on clear_start.
- clear_busy, out, 1, high while a clear is in progress.
- clear_done, out, 1, one-cycle pulse when a clear completes.
- addr_err, out, 1, one-cycle pulse when an out-of-range write is dropped.
- fbuf_en_wr, out, 1, BRAM port enable.
- fbuf_wrea, out, 1, BRAM write enable.
- fbuf_addr, out, FBUF_ADDR_WIDTH, BRAM address.
- fbuf_data, out, FBUF_DATA_WIDTH, BRAM write data.

REQ-003 Clock and reset: one clock, clk. Reset is rst, asynchronous and active-high.

Function
REQ-004 The block SHALL have two states, ARB and CLEAR.

REQ-005 Readiness:
- In ARB, r0_ready and r1_ready SHALL be combinational from state, valids, grant pointer and fbuf_rst_busy.
- At most one ready SHALL be high per cycle.
- Both readies SHALL be 0 when fbuf_rst_busy=1 or in CLEAR.

REQ-006 Arbitration SHALL be round-robin:
- Only one valid: that requester gets ready.
- Both valid: the requester not granted most recently gets ready.
- The pointer updates only on an accepted handshake and resets to "last granted = 1", so requester 0 wins the first tie.

REQ-007 On handshake (rN_valid && rN_ready) at cycle T, at T+1 fbuf_en_wr=fbuf_wrea=1 with the registered address and data. Latency is exactly 1 cycle; throughput is 1 write per cycle.

REQ-008 Cycles with no issued write SHALL drive fbuf_en_wr=fbuf_wrea=0. fbuf_addr and fbuf_data SHALL hold their last values.

REQ-009 Out-of-range handshake (address >= FRAME_PIXELS):
- The request is accepted.
- No write is issued.
- addr_err=1 at T+1 for one cycle.

REQ-010 Clear start:
- clear_start in ARB with fbuf_rst_busy=0 SHALL latch clear_color, zero the counter and enter CLEAR next cycle.
- If a handshake occurs in the same cycle, clear wins: readies are forced to 0 that cycle.

REQ-011 In CLEAR, clear_busy=1:
- Each cycle with fbuf_rst_busy=0 issues a write (counter, color) and increments the counter.
- Cycles with fbuf_rst_busy=1 issue nothing and hold the counter.

REQ-012 Clear completion:
- The write at counter FRAME_PIXELS-1 is the last.
- clear_done=1 in the same cycle that last write appears on the port.
- Return to ARB the following cycle.
- Exactly FRAME_PIXELS writes per clear.

REQ-013 clear_start received while in CLEAR, or while fbuf_rst_busy=1 in ARB, SHALL be ignored (not queued).

REQ-014 The counter SHALL be FBUF_ADDR_WIDTH bits and SHALL never exceed FRAME_PIXELS-1.

Reset
REQ-015 rst asserted at any time, including mid-clear or mid-write, SHALL asynchronously force:
- state=ARB, counter=0.
- fbuf_en_wr=fbuf_wrea=0, fbuf_addr=0, fbuf_data=0.
- clear_busy=0, clear_done=0, addr_err=0.
- Grant pointer = "last granted 1".
- r0_ready=r1_ready=0 while rst=1.

REQ-016 After rst deassertion, no write SHALL be issued until a new handshake or clear_start.

Verification
REQ-017 Single request: r0_valid with addr=5, data=0xA3 -> r0_ready=1 same cycle; next cycle en_wr=wrea=1, addr=5, data=0xA3.

REQ-018 Contention: r0 and r1 both valid for 4 cycles (post-reset) -> grants 0,1,0,1; writes appear one cycle after each grant.

REQ-019 Range: r1 addr=307200 -> r1_ready=1, no write, addr_err pulses once; addr=307199 -> normal write.

REQ-020 Clear: clear_start with color=0x1F -> 307200 consecutive writes, addresses 0..307199, data 0x1F; clear_done on the last; readies 0 throughout; a second clear_start mid-clear is ignored.

REQ-021 Stall: fbuf_rst_busy=1 for 3 cycles mid-clear at counter 100 -> no writes for 3 cycles, resumes at 100, total writes still 307200.

REQ-022 Reset mid-clear: rst at counter 1000 -> all outputs 0 immediately; after release, state ARB and r0 request accepted normally.

Source files
------------

// File: rtl/fbuf_write_scheduler.sv
// ---------------------------------------------------------------------------
// fbuf_write_scheduler
//
// Single write port scheduler for the framebuffer BRAM. Two pixel-write
// requesters (register decode path and drawing engine) share the port under
// round-robin arbitration. A full-frame clear engine can take the port over
// and fill every pixel with one colour. All BRAM-side outputs are registered,
// so a write appears on the port exactly one cycle after it is accepted.
//
// Ports
//   clk, rst            single clock, asynchronous active-high reset
//   fbuf_rst_busy       BRAM is resetting itself; nothing may be written
//   r0_*                requester 0 valid/ready write channel (addr, data)
//   r1_*                requester 1 valid/ready write channel (addr, data)
//   clear_start         one-cycle pulse starting a full-frame clear
//   clear_color         fill value, captured with clear_start
//   clear_busy          clear in progress
//   clear_done          pulse aligned with the last clear write on the port
//   addr_err            pulse one cycle after an out-of-range write is dropped
//   fbuf_en_wr/wrea     BRAM port enable / write enable
//   fbuf_addr/data      BRAM address / write data (hold when idle)
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_ARB   | requesters arbitrated round-robin; clear_start may be accepted
// ST_CLEAR | clear engine owns the port, one pixel per non-stalled cycle
// ---------------------------------------------------------------------------
module fbuf_write_scheduler #(
   parameter int FBUF_ADDR_WIDTH = 19,
   parameter int FBUF_DATA_WIDTH = 8,
   parameter int FRAME_PIXELS    = 307200
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       fbuf_rst_busy,
   input  logic                       r0_valid,
   output logic                       r0_ready,
   input  logic [FBUF_ADDR_WIDTH-1:0] r0_addr,
   input  logic [FBUF_DATA_WIDTH-1:0] r0_data,
   input  logic                       r1_valid,
   output logic                       r1_ready,
   input  logic [FBUF_ADDR_WIDTH-1:0] r1_addr,
   input  logic [FBUF_DATA_WIDTH-1:0] r1_data,
   input  logic                       clear_start,
   input  logic [FBUF_DATA_WIDTH-1:0] clear_color,
   output logic                       clear_busy,
   output logic                       clear_done,
   output logic                       addr_err,
   output logic                       fbuf_en_wr,
   output logic                       fbuf_wrea,
   output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
   output logic [FBUF_DATA_WIDTH-1:0] fbuf_data
);

   localparam logic [FBUF_ADDR_WIDTH-1:0] LAST_PIXEL  = FBUF_ADDR_WIDTH'(FRAME_PIXELS - 1);
   localparam logic [FBUF_ADDR_WIDTH:0]   PIXEL_LIMIT = (FBUF_ADDR_WIDTH + 1)'(FRAME_PIXELS);
   localparam logic [FBUF_ADDR_WIDTH-1:0] CNT_ONE     = {{(FBUF_ADDR_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic {
      ST_ARB   = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   state_t                       state_q, state_d;
   logic [FBUF_ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic [FBUF_DATA_WIDTH-1:0]   color_q, color_d;
   // 1 = requester 1 was granted most recently, so requester 0 wins the next tie
   logic                         last_grant_q, last_grant_d;

   logic                         wr_d;
   logic [FBUF_ADDR_WIDTH-1:0]   waddr_d;
   logic [FBUF_DATA_WIDTH-1:0]   wdata_d;
   logic                         err_d;
   logic                         done_d;

   logic                         clear_go;
   logic                         arb_open;
   logic                         r0_hs;
   logic                         r1_hs;
   logic                         r0_in_range;
   logic                         r1_in_range;

   // A clear request takes priority over any handshake in the same cycle,
   // hence arb_open also excludes clear_start.
   assign clear_go    = (state_q == ST_ARB) && clear_start && !fbuf_rst_busy;
   assign arb_open    = (state_q == ST_ARB) && !fbuf_rst_busy && !clear_start && !rst;

   assign r0_ready    = arb_open && r0_valid && (!r1_valid || last_grant_q);
   assign r1_ready    = arb_open && r1_valid && (!r0_valid || !last_grant_q);
   assign r0_hs       = r0_valid && r0_ready;
   assign r1_hs       = r1_valid && r1_ready;

   assign r0_in_range = {1'b0, r0_addr} < PIXEL_LIMIT;
   assign r1_in_range = {1'b0, r1_addr} < PIXEL_LIMIT;

   assign clear_busy  = (state_q == ST_CLEAR);
   assign fbuf_wrea   = fbuf_en_wr;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      color_d      = color_q;
      last_grant_d = last_grant_q;
      wr_d         = 1'b0;
      waddr_d      = fbuf_addr;
      wdata_d      = fbuf_data;
      err_d        = 1'b0;
      done_d       = 1'b0;

      case (state_q)
         ST_ARB: begin
            if (clear_go) begin
               state_d = ST_CLEAR;
               cnt_d   = '0;
               color_d = clear_color;
            end else if (r0_hs) begin
               last_grant_d = 1'b0;
               if (r0_in_range) begin
                  wr_d    = 1'b1;
                  waddr_d = r0_addr;
                  wdata_d = r0_data;
               end else begin
                  err_d   = 1'b1;
               end
            end else if (r1_hs) begin
               last_grant_d = 1'b1;
               if (r1_in_range) begin
                  wr_d    = 1'b1;
                  waddr_d = r1_addr;
                  wdata_d = r1_data;
               end else begin
                  err_d   = 1'b1;
               end
            end
         end

         ST_CLEAR: begin
            if (!fbuf_rst_busy) begin
               wr_d    = 1'b1;
               waddr_d = cnt_q;
               wdata_d = color_q;
               if (cnt_q == LAST_PIXEL) begin
                  // done is registered alongside the last write so both
                  // appear on the port in the same cycle
                  done_d  = 1'b1;
                  state_d = ST_ARB;
                  cnt_d   = '0;
               end else begin
                  cnt_d   = cnt_q + CNT_ONE;
               end
            end
         end

         default: begin
            state_d = ST_ARB;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_ARB;
         cnt_q        <= '0;
         color_q      <= '0;
         last_grant_q <= 1'b1;
         fbuf_en_wr   <= 1'b0;
         fbuf_addr    <= '0;
         fbuf_data    <= '0;
         addr_err     <= 1'b0;
         clear_done   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         color_q      <= color_d;
         last_grant_q <= last_grant_d;
         fbuf_en_wr   <= wr_d;
         fbuf_addr    <= waddr_d;
         fbuf_data    <= wdata_d;
         addr_err     <= err_d;
         clear_done   <= done_d;
      end
   end

endmodule
